// File: rtl/alu_cmd_sender.sv
// Serialises one ALU command (A, B, opcode) as three back-to-back 8N1 UART bytes.
// Carries its own 16x-oversample tick divider so it can drive a UART receiver directly.
module alu_cmd_sender #(
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned OPCODE_SIZE = 6,
    parameter int unsigned FR_CLOCK_HZ = 100000000,
    parameter int unsigned BAUDRATE    = 9600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned TICK_DIV    = FR_CLOCK_HZ / (BAUDRATE * OVERSAMPLE)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DATA_SIZE-1:0]   i_a,
    input  logic [DATA_SIZE-1:0]   i_b,
    input  logic [OPCODE_SIZE-1:0] i_op,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = $clog2(BYTE_W);
    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OS_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [OS_W-1:0]   os_q, os_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [BYTE_W-1:0] a_q, a_d;
    logic [BYTE_W-1:0] b_q, b_d;
    logic [BYTE_W-1:0] op_q, op_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick_c;
    logic              bit_end_c;
    logic [BYTE_W-1:0] cur_byte_c;
    logic [BIT_W-1:0]  next_bit_c;

    assign tick_c     = (div_q == DIV_W'(TICK_DIV - 1));
    assign bit_end_c  = tick_c && (os_q == OS_W'(OVERSAMPLE - 1));
    assign next_bit_c = bit_q + BIT_W'(1);

    always_comb begin
        cur_byte_c = op_q;
        case (byte_q)
            2'd0:    cur_byte_c = a_q;
            2'd1:    cur_byte_c = b_q;
            default: cur_byte_c = op_q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        os_d    = os_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                os_d = bit_end_c ? '0 : os_q + OS_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_start) begin
                    a_d     = BYTE_W'(i_a);
                    b_d     = BYTE_W'(i_b);
                    op_d    = BYTE_W'(i_op);
                    byte_d  = 2'd0;
                    div_d   = '0;
                    os_d    = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    bit_d   = '0;
                    tx_d    = cur_byte_c[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(BYTE_W - 1)) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = next_bit_c;
                        tx_d  = cur_byte_c[next_bit_c];
                    end
                end
            end
            default: begin
                if (bit_end_c) begin
                    if (byte_q == 2'd2) begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Directed bench for alu_cmd_sender: a line decoder pops expected bytes from a scoreboard queue.
// TICK_DIV=1 with 16x oversample, so one bit is 16 clocks and one command 480 clocks.
module tb_alu_cmd_sender;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int n;
    int base;

    logic [7:0] sb[$];

    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_exp;

    alu_cmd_sender #(
        .DATA_SIZE  (8),
        .OPCODE_SIZE(6),
        .FR_CLOCK_HZ(160),
        .BAUDRATE   (10),
        .OVERSAMPLE (16)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_start(start),
        .i_a    (a),
        .i_b    (b),
        .i_op   (op),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Line decoder: samples mid-bit, checks start/stop bits and pops the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 8) chk("start_bit", 32'(tx), 32'd0);
            if (mon_cnt >= 24 && mon_cnt <= 136 && ((mon_cnt - 8) % 16) == 0)
                mon_byte = {tx, mon_byte[7:1]};
            if (mon_cnt == 152) begin
                chk("stop_bit", 32'(tx), 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_byte", 32'(mon_byte), 32'hFFFF_FFFF);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("line_byte", 32'(mon_byte), 32'(mon_exp));
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic send(input bit align, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [5:0] top);
        if (align) begin
            @(posedge clk);
            #1;
        end
        a = ta;
        b = tb;
        op = top;
        start = 1'b1;
        sb.push_back(ta);
        sb.push_back(tb);
        sb.push_back({2'b00, top});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("tx_after_accept", 32'(tx), 32'd0);
    endtask

    task automatic wait_done(input int offset, output int cycles);
        cycles = offset;
        while (done !== 1'b1 && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        op = 6'h00;
        #2 rst = 1'b1;

        // Reset held: start must be ignored and the line idle.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single command.
        base = done_cnt;
        send(1'b1, 8'h5A, 8'h03, 6'b100000);
        wait_done(0, n);
        chk("single_latency", 32'(n), 32'd480);
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("single_done_tx", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        repeat (20) @(posedge clk);
        chk("single_done_count", 32'(done_cnt - base), 32'd1);

        // Start while busy is ignored.
        base = done_cnt;
        send(1'b1, 8'hFF, 8'h01, 6'h01);
        repeat (99) @(posedge clk);
        #1;
        a = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100, n);
        chk("busy_latency", 32'(n), 32'd480);
        repeat (40) @(posedge clk);
        #1;
        chk("busy_idle_after", 32'(busy), 32'd0);
        chk("busy_done_count", 32'(done_cnt - base), 32'd1);

        // Back-to-back: second start on the done cycle.
        base = done_cnt;
        send(1'b1, 8'hC3, 8'h3C, 6'h2A);
        wait_done(0, n);
        chk("b2b_first_latency", 32'(n), 32'd480);
        send(1'b0, 8'h11, 8'h22, 6'h3F);
        wait_done(0, n);
        chk("b2b_second_latency", 32'(n), 32'd480);
        repeat (20) @(posedge clk);
        chk("b2b_done_count", 32'(done_cnt - base), 32'd2);
        chk("b2b_queue_empty", 32'(sb.size()), 32'd0);

        // Reset mid-frame during byte 1, bit 4 (B=0 so the line is low there).
        send(1'b1, 8'h0F, 8'h00, 6'h15);
        repeat (247) @(posedge clk);
        #1;
        chk("pre_reset_tx", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_rst_idle_tx", 32'(tx), 32'd1);
            chk("post_rst_idle_busy", 32'(busy), 32'd0);
        end
        base = done_cnt;
        send(1'b1, 8'hA5, 8'h5A, 6'h12);
        wait_done(0, n);
        chk("post_rst_latency", 32'(n), 32'd480);
        repeat (20) @(posedge clk);
        chk("post_rst_done_count", 32'(done_cnt - base), 32'd1);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sender.md
Name: alu_cmd_sender

Overview:
- Upstream stimulus stage for the UART/ALU top. It takes one ALU command (operand A, operand B, opcode) and serialises it onto a single UART line that drives the top's receive input.
- Each command goes out as three back-to-back 8N1 bytes in the order the interface collector expects: A, B, opcode.
- The block has its own 16x-oversample tick divider and the same baud configuration as the receiver, so it serves as a self-test source on board and as the bench driver.

Parameters:
- DATA_SIZE, 8, width of operands A and B; must equal the UART byte width (8).
- OPCODE_SIZE, 6, opcode width; must be ≤ 8; zero-extended to 8 bits on the line.
- FR_CLOCK_HZ, 100000000, system clock frequency in Hz.
- BAUDRATE, 9600, line baud rate.
- OVERSAMPLE, 16, ticks per bit period.
- TICK_DIV, FR_CLOCK_HZ/(BAUDRATE*OVERSAMPLE) (integer division, 651 by default), clocks per tick; must be ≥ 1.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to send a command.
- i_a  in  DATA_SIZE  operand A.
- i_b  in  DATA_SIZE  operand B.
- i_op  in  OPCODE_SIZE  ALU opcode.
- o_tx  out  1  serial line; idle high.
- o_busy  out  1  high while a command is being transmitted.
- o_done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (asynchronous, active high), applied at any time including mid-frame:
  - o_tx=1, o_busy=0, o_done=0.
  - FSM returns to IDLE; the divider, tick, bit and byte counters clear; the latched command clears.
  - After reset release the line stays idle until the next i_start.
- Accept rule:
  - i_start is sampled on a rising edge while o_busy=0; i_a, i_b and {zeros, i_op} are latched on that edge.
  - i_start while o_busy=1 is ignored; nothing is queued.
- Divider:
  - On accept it clears to 0 and then counts 0..TICK_DIV-1, producing a one-cycle tick at TICK_DIV-1.
  - Each bit lasts OVERSAMPLE ticks, i.e. OVERSAMPLE*TICK_DIV clocks.
- FSM states:
  - IDLE: o_tx=1. Accept → START with byte index 0.
  - START: o_tx=0 for one bit period → DATA with bit index 0.
  - DATA: o_tx=current byte[bit index], LSB first, one bit period per bit. After bit 7 → STOP.
  - STOP: o_tx=1 for one bit period. Then, if byte index < 2, increment it → START. If byte index = 2 → IDLE.
- Byte order: byte 0 = A, byte 1 = B, byte 2 = {(8-OPCODE_SIZE) zeros, op}.
- There is no inter-byte gap beyond the single stop bit.
- Timing, with accept at edge T:
  - o_busy=1 and o_tx=0 (start bit of byte 0) are visible from cycle T+1.
  - A full command lasts 30*OVERSAMPLE*TICK_DIV clocks.
  - On the cycle after the final stop bit completes: o_done=1 for exactly one cycle, o_busy=0, o_tx=1.
- Back-to-back commands: i_start asserted on the cycle o_done pulses is accepted, since o_busy is already 0. The next start bit follows with no extra idle bit.
- All outputs are registered; o_tx is glitch-free.

Test Plan:
(Bench parameters: FR_CLOCK_HZ=160, BAUDRATE=10, so TICK_DIV=1 and a bit lasts 16 clocks; a command is 480 clocks.)
- Reset state: hold i_reset high, pulse i_start → o_tx=1, o_busy=0, o_done=0 throughout.
- Single command A=0x5A, B=0x03, op=6'b100000 → line decodes to 0x5A, 0x03, 0x20. Each start bit is 0 and each stop bit is 1. o_done pulses once, 480 clocks after accept.
- Start while busy: accept A=0xFF, B=0x01, op=0x01, then pulse i_start with A=0x00 at clock 100 → transmitted bytes are still 0xFF, 0x01, 0x01, and only one o_done pulse occurs.
- Back-to-back: issue a second i_start (A=0x11, B=0x22, op=0x3F) on the o_done cycle → six bytes on the line with no idle gap between commands. The sixth byte is 0x3F with bits 7:6 = 0.
- Reset mid-frame: assert i_reset asynchronously during byte 1, bit 4 → o_tx goes high within the same cycle and o_busy=0. After release, a new command (0xA5, 0x5A, 0x12) is sent correctly.
- End-to-end: connect o_tx to the UART top's receive input, send A=0x07, B=0x05, op=ADD opcode → the top's a and b outputs read 0x07 and 0x05, and its o_tx returns the byte 0x0C.
